// File: rtl/mips_pkg.sv
// Shared MIPS encodings, Tuse/Tnew constants and pipeline types for the hazard tracker.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;
  localparam logic [1:0] TUSE_NONE   = 2'd3;

  localparam logic [1:0] TNEW_PC8  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {MDU_NONE, MDU_MULT, MDU_DIV, MDU_MOVE} mdu_op_t;

  typedef struct packed {
    logic [4:0] write_reg;
    logic       reg_write;
    logic [1:0] tnew;
    logic       mem_write;
  } stage_t;

  // Tnew counts down as an instruction ages but must stick at 0, never wrap to 3.
  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x != 2'd0) ? x - 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// D-stage decoder: instruction -> Tuse/Tnew/destination info. MDU_EN adds mult/div/hi/lo decode.
module instr_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew,
  output logic [4:0]  write_reg,
  output logic        reg_write,
  output logic        mem_write
`ifdef MDU_EN
  ,
  output mdu_op_t     mdu_op
`endif
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [1:0] tnew_raw;
  logic [4:0] dst;
  logic       has_dst;
  logic       unused_bits;

  assign op    = instr[31:26];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through the cases infers a latch.
    tuse_rs   = TUSE_NONE;
    tuse_rt   = TUSE_NONE;
    tnew_raw  = TNEW_PC8;
    dst       = REG_ZERO;
    has_dst   = 1'b0;
    mem_write = 1'b0;
`ifdef MDU_EN
    mdu_op    = MDU_NONE;
`endif
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: begin
            tuse_rs  = TUSE_ALU;
            tuse_rt  = TUSE_ALU;
            tnew_raw = TNEW_ALU;
            dst      = rd;
            has_dst  = 1'b1;
          end
          FN_JR: tuse_rs = TUSE_BRANCH;
`ifdef MDU_EN
          FN_MULT, FN_DIV: begin
            tuse_rs = TUSE_ALU;
            tuse_rt = TUSE_ALU;
            mdu_op  = (funct == FN_MULT) ? MDU_MULT : MDU_DIV;
          end
          FN_MFHI, FN_MFLO: begin
            tnew_raw = TNEW_ALU;
            dst      = rd;
            has_dst  = 1'b1;
            mdu_op   = MDU_MOVE;
          end
          FN_MTHI, FN_MTLO: begin
            tuse_rs = TUSE_ALU;
            mdu_op  = MDU_MOVE;
          end
`endif
          default: ;
        endcase
      end
      OP_ORI: begin
        tuse_rs  = TUSE_ALU;
        tnew_raw = TNEW_ALU;
        dst      = rt;
        has_dst  = 1'b1;
      end
      OP_LUI: begin
        tnew_raw = TNEW_ALU;
        dst      = rt;
        has_dst  = 1'b1;
      end
      OP_LW: begin
        tuse_rs  = TUSE_ALU;
        tnew_raw = TNEW_LOAD;
        dst      = rt;
        has_dst  = 1'b1;
      end
      OP_SW: begin
        tuse_rs   = TUSE_ALU;
        tuse_rt   = TUSE_STORE;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        tuse_rs = TUSE_BRANCH;
        tuse_rt = TUSE_BRANCH;
      end
      OP_JAL: begin
        tnew_raw = TNEW_PC8;
        dst      = REG_RA;
        has_dst  = 1'b1;
      end
      default: ;
    endcase
  end

  // Writes to $0 are architecturally dead, so they must never look like a producer.
  assign write_reg = has_dst ? dst : REG_ZERO;
  assign reg_write = has_dst && (dst != REG_ZERO);
  assign tnew      = reg_write ? tnew_raw : TNEW_PC8;

endmodule

// File: rtl/hazard_tracker.sv
// Carries decoded Tuse/Tnew/destination info through E/M/W. MDU_EN adds the mult/div busy stall.
module hazard_tracker
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_d,
  input  logic        flush_e,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew_d,
  output logic [4:0]  rs_d,
  output logic [4:0]  rt_d,
  output logic [4:0]  rs_e,
  output logic [4:0]  rt_e,
  output logic [4:0]  write_reg_e,
  output logic [4:0]  write_reg_m,
  output logic [4:0]  write_reg_w,
  output logic        reg_write_e,
  output logic        reg_write_m,
  output logic        reg_write_w,
  output logic [1:0]  tnew_e,
  output logic [1:0]  tnew_m,
  output logic [1:0]  tnew_w,
  output logic        mem_write_m,
  output logic        mdu_stall
);

  stage_t     dec_d;
  stage_t     e_q;
  stage_t     m_q;
  logic [4:0] write_reg_dec;
  logic       reg_write_dec;
  logic       mem_write_dec;

  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];

`ifdef MDU_EN
  mdu_op_t mdu_op_d;
  mdu_op_t mdu_op_e;
`endif

  instr_decoder u_decoder (
    .instr     (instr_d),
    .tuse_rs   (tuse_rs),
    .tuse_rt   (tuse_rt),
    .tnew      (tnew_d),
    .write_reg (write_reg_dec),
    .reg_write (reg_write_dec),
    .mem_write (mem_write_dec)
`ifdef MDU_EN
    ,
    .mdu_op    (mdu_op_d)
`endif
  );

  assign dec_d = '{write_reg: write_reg_dec, reg_write: reg_write_dec,
                   tnew: tnew_d, mem_write: mem_write_dec};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q         <= '0;
      rs_e        <= '0;
      rt_e        <= '0;
      m_q         <= '0;
      write_reg_w <= '0;
      reg_write_w <= 1'b0;
      tnew_w      <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage read the previous stage's pre-edge value.
      if (flush_e) begin
        e_q  <= '0;
        rs_e <= '0;
        rt_e <= '0;
      end else begin
        e_q  <= dec_d;
        rs_e <= rs_d;
        rt_e <= rt_d;
      end
      m_q <= '{write_reg: e_q.write_reg, reg_write: e_q.reg_write,
               tnew: sat_dec(e_q.tnew), mem_write: e_q.mem_write};
      write_reg_w <= m_q.write_reg;
      reg_write_w <= m_q.reg_write;
      tnew_w      <= sat_dec(m_q.tnew);
    end
  end

  assign write_reg_e = e_q.write_reg;
  assign reg_write_e = e_q.reg_write;
  assign tnew_e      = e_q.tnew;
  assign write_reg_m = m_q.write_reg;
  assign reg_write_m = m_q.reg_write;
  assign tnew_m      = m_q.tnew;
  assign mem_write_m = m_q.mem_write;

`ifdef MDU_EN
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] busy_cnt;

  // The counter starts when mult/div leaves E; while it is still in E the E check covers it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdu_op_e <= MDU_NONE;
      busy_cnt <= '0;
    end else begin
      mdu_op_e <= flush_e ? MDU_NONE : mdu_op_d;
      if (mdu_op_e == MDU_MULT)
        busy_cnt <= CNT_W'(MULT_CYCLES);
      else if (mdu_op_e == MDU_DIV)
        busy_cnt <= CNT_W'(DIV_CYCLES);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - CNT_W'(1);
    end
  end

  assign mdu_stall = (mdu_op_d != MDU_NONE) &&
                     ((busy_cnt != '0) || (mdu_op_e == MDU_MULT) || (mdu_op_e == MDU_DIV));
`else
  logic unused_cfg;
  assign unused_cfg = (MULT_CYCLES + DIV_CYCLES) != 0;
  assign mdu_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Randomized self-checking bench for hazard_tracker against a stage-age reference model.
module tb_hazard_tracker;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JR, K_J, K_JAL,
                    K_NOP, K_UNK, K_RUNK, K_MULT, K_DIV, K_MFHI, K_MFLO, K_MTHI, K_MTLO} kind_t;

  typedef struct {
    logic [1:0] tuse_rs, tuse_rt, tnew;
    logic [4:0] wreg;
    logic       we, mw;
    bit         muldiv, is_div, mdu_any;
  } attr_t;

  typedef struct {
    attr_t      a;
    logic [4:0] rs, rt;
  } ent_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr_d;
  logic        flush_e;
  logic [1:0]  tuse_rs, tuse_rt, tnew_d;
  logic [4:0]  rs_d, rt_d, rs_e, rt_e;
  logic [4:0]  write_reg_e, write_reg_m, write_reg_w;
  logic        reg_write_e, reg_write_m, reg_write_w;
  logic [1:0]  tnew_e, tnew_m, tnew_w;
  logic        mem_write_m;
  logic        mdu_stall;

  hazard_tracker #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_d     (instr_d),
    .flush_e     (flush_e),
    .tuse_rs     (tuse_rs),
    .tuse_rt     (tuse_rt),
    .tnew_d      (tnew_d),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .rs_e        (rs_e),
    .rt_e        (rt_e),
    .write_reg_e (write_reg_e),
    .write_reg_m (write_reg_m),
    .write_reg_w (write_reg_w),
    .reg_write_e (reg_write_e),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .tnew_e      (tnew_e),
    .tnew_m      (tnew_m),
    .tnew_w      (tnew_w),
    .mem_write_m (mem_write_m),
    .mdu_stall   (mdu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  ent_t        pipe_q[$];     // [0]=E, [1]=M, [2]=W
  attr_t       cur_attr;
  logic [31:0] cur_instr;
  int          cyc = 0;
  int          busy_until = -100;
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input kind_t k, input logic [4:0] rs, rt, rd);
    logic [15:0] imm;
    logic [4:0]  sh;
    logic [31:0] e;
    imm = 16'($urandom);
    sh  = 5'($urandom);
    case (k)
      K_ADDU:  e = {6'h00, rs, rt, rd, sh, 6'h21};
      K_SUBU:  e = {6'h00, rs, rt, rd, sh, 6'h23};
      K_JR:    e = {6'h00, rs, rt, rd, sh, 6'h08};
      K_RUNK:  e = {6'h00, rs, rt, rd, sh, 6'h2a};
      K_MULT:  e = {6'h00, rs, rt, rd, sh, 6'h18};
      K_DIV:   e = {6'h00, rs, rt, rd, sh, 6'h1a};
      K_MFHI:  e = {6'h00, rs, rt, rd, sh, 6'h10};
      K_MFLO:  e = {6'h00, rs, rt, rd, sh, 6'h12};
      K_MTHI:  e = {6'h00, rs, rt, rd, sh, 6'h11};
      K_MTLO:  e = {6'h00, rs, rt, rd, sh, 6'h13};
      K_ORI:   e = {6'h0d, rs, rt, imm};
      K_LUI:   e = {6'h0f, rs, rt, imm};
      K_LW:    e = {6'h23, rs, rt, imm};
      K_SW:    e = {6'h2b, rs, rt, imm};
      K_BEQ:   e = {6'h04, rs, rt, imm};
      K_J:     e = {6'h02, 26'($urandom)};
      K_JAL:   e = {6'h03, 26'($urandom)};
      K_UNK:   e = {6'h3f, 26'($urandom)};
      default: e = 32'h0;
    endcase
    return e;
  endfunction

  function automatic attr_t attr_of(input kind_t k, input logic [4:0] rt, rd);
    attr_t      a;
    bit         has_dst;
    logic [4:0] dst;
    a.tuse_rs = 2'd3; a.tuse_rt = 2'd3; a.tnew = 2'd0; a.mw = 1'b0;
    a.muldiv = 0; a.is_div = 0; a.mdu_any = 0;
    has_dst = 0; dst = 5'd0;
    case (k)
      K_ADDU, K_SUBU: begin a.tuse_rs = 1; a.tuse_rt = 1; a.tnew = 1; has_dst = 1; dst = rd; end
      K_ORI:  begin a.tuse_rs = 1; a.tnew = 1; has_dst = 1; dst = rt; end
      K_LUI:  begin a.tnew = 1; has_dst = 1; dst = rt; end
      K_LW:   begin a.tuse_rs = 1; a.tnew = 2; has_dst = 1; dst = rt; end
      K_SW:   begin a.tuse_rs = 1; a.tuse_rt = 2; a.mw = 1'b1; end
      K_BEQ:  begin a.tuse_rs = 0; a.tuse_rt = 0; end
      K_JR:   a.tuse_rs = 0;
      K_JAL:  begin a.tnew = 0; has_dst = 1; dst = 5'd31; end
`ifdef MDU_EN
      K_MULT, K_DIV: begin
        a.tuse_rs = 1; a.tuse_rt = 1; a.muldiv = 1; a.is_div = (k == K_DIV); a.mdu_any = 1;
      end
      K_MFHI, K_MFLO: begin a.tnew = 1; has_dst = 1; dst = rd; a.mdu_any = 1; end
      K_MTHI, K_MTLO: begin a.tuse_rs = 1; a.mdu_any = 1; end
`endif
      default: ;
    endcase
    a.wreg = has_dst ? dst : 5'd0;
    a.we   = has_dst && (dst != 5'd0);
    if (!a.we) a.tnew = 2'd0;
    return a;
  endfunction

  function automatic ent_t bubble();
    ent_t b;
    b.a.tuse_rs = 0; b.a.tuse_rt = 0; b.a.tnew = 0; b.a.wreg = 0; b.a.we = 0; b.a.mw = 0;
    b.a.muldiv = 0; b.a.is_div = 0; b.a.mdu_any = 0;
    b.rs = 0; b.rt = 0;
    return b;
  endfunction

  // Tnew seen at a stage is the decoded value minus the entry's age past E, floored at 0.
  function automatic int aged(input logic [1:0] t0, input int depth);
    return (int'(t0) > depth) ? int'(t0) - depth : 0;
  endfunction

  task automatic model_reset();
    pipe_q = {};
    for (int i = 0; i < 3; i++) pipe_q.push_back(bubble());
    busy_until = -100;
  endtask

  task automatic drive_d(input kind_t k, input logic [4:0] rs, rt, rd, input logic fl);
    cur_instr = enc(k, rs, rt, rd);
    cur_attr  = attr_of(k, rt, rd);
    instr_d   = cur_instr;
    flush_e   = fl;
  endtask

  task automatic compare_all();
    logic exp_stall;
    check("tuse_rs", tuse_rs, cur_attr.tuse_rs);
    check("tuse_rt", tuse_rt, cur_attr.tuse_rt);
    check("tnew_d", tnew_d, cur_attr.tnew);
    check("rs_d", rs_d, cur_instr[25:21]);
    check("rt_d", rt_d, cur_instr[20:16]);
    check("rs_e", rs_e, pipe_q[0].rs);
    check("rt_e", rt_e, pipe_q[0].rt);
    check("write_reg_e", write_reg_e, pipe_q[0].a.wreg);
    check("reg_write_e", reg_write_e, pipe_q[0].a.we);
    check("tnew_e", tnew_e, aged(pipe_q[0].a.tnew, 0));
    check("write_reg_m", write_reg_m, pipe_q[1].a.wreg);
    check("reg_write_m", reg_write_m, pipe_q[1].a.we);
    check("tnew_m", tnew_m, aged(pipe_q[1].a.tnew, 1));
    check("mem_write_m", mem_write_m, pipe_q[1].a.mw);
    check("write_reg_w", write_reg_w, pipe_q[2].a.wreg);
    check("reg_write_w", reg_write_w, pipe_q[2].a.we);
    check("tnew_w", tnew_w, aged(pipe_q[2].a.tnew, 2));
`ifdef MDU_EN
    exp_stall = cur_attr.mdu_any && ((cyc <= busy_until) || pipe_q[0].a.muldiv);
`else
    exp_stall = 1'b0;
`endif
    check("mdu_stall", mdu_stall, exp_stall);
  endtask

  task automatic advance(input logic fl);
    ent_t n;
    if (pipe_q[0].a.muldiv) busy_until = cyc + (pipe_q[0].a.is_div ? DIV_N : MULT_N);
    if (fl) n = bubble();
    else begin
      n.a  = cur_attr;
      n.rs = cur_instr[25:21];
      n.rt = cur_instr[20:16];
    end
    pipe_q.push_front(n);
    void'(pipe_q.pop_back());
    cyc++;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input kind_t k, input logic [4:0] rs, rt, rd, input logic fl);
    drive_d(k, rs, rt, rd, fl);
    @(negedge clk);
    compare_all();
    last_stall = mdu_stall;
    @(posedge clk);
    advance(fl);
    #1;
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  initial begin : main
    int    n_stall;
    kind_t k;
    reset_n = 1'b0;
    model_reset();
    drive_d(K_LW, 5'd3, 5'd5, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    check("rst_tnew_e", tnew_e, 0);
    check("rst_write_reg_e", write_reg_e, 0);
    check("rst_reg_write_w", reg_write_w, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    cycle(K_LW, 5'd3, 5'd5, 5'd0, 1'b0);
    check("lw_tnew_e", tnew_e, 2);
    check("lw_write_reg_e", write_reg_e, 5);

    cycle(K_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    cycle(K_ADDU, 5'd8, 5'd8, 5'd9, 1'b0);
    check("lw8_tnew_m", tnew_m, 1);
    cycle(K_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    check("lw8_tnew_w", tnew_w, 0);
    check("lw8_write_reg_w", write_reg_w, 8);

    cycle(K_JAL, 5'd0, 5'd0, 5'd0, 1'b0);
    check("jal_write_reg_e", write_reg_e, 31);
    check("jal_reg_write_e", reg_write_e, 1);
    check("jal_tnew_e", tnew_e, 0);

    cycle(K_ADDU, 5'd1, 5'd2, 5'd0, 1'b0);
    check("r0_reg_write_e", reg_write_e, 0);
    check("r0_tnew_e", tnew_e, 0);

    cycle(K_SW, 5'd2, 5'd7, 5'd0, 1'b1);
    check("flush1_rs_e", rs_e, 0);
    cycle(K_SW, 5'd2, 5'd7, 5'd0, 1'b1);
    check("flush2_mem_write_m", mem_write_m, 0);
    cycle(K_SW, 5'd2, 5'd7, 5'd0, 1'b0);
    check("flush3_mem_write_m", mem_write_m, 0);
    check("sw_rs_e", rs_e, 2);
    cycle(K_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    check("sw_mem_write_m", mem_write_m, 1);

    cycle(K_MULT, 5'd1, 5'd2, 5'd0, 1'b0);
    n_stall = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(K_MFHI, 5'd0, 5'd0, 5'd4, 1'b1);
      if (last_stall === 1'b1) n_stall++;
    end
    cycle(K_MFHI, 5'd0, 5'd0, 5'd4, 1'b0);
`ifdef MDU_EN
    check("mult_stall_cycles", n_stall, 1 + MULT_N);
    check("mfhi_reg_write_e", reg_write_e, 1);
`else
    check("mult_stall_cycles", n_stall, 0);
    check("mfhi_reg_write_e", reg_write_e, 0);
`endif

    for (int i = 0; i < 600; i++) begin
      k = kind_t'($urandom_range(0, 18));
      if ($urandom_range(0, 99) == 0) async_reset();
      cycle(k, 5'($urandom), 5'($urandom), 5'($urandom), $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
